// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// LS has priority; a starvation counter bounds how long fetch can wait.
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               owner_q, owner_d;

    logic               resp;
    logic               can_issue;
    logic               pick_if;
    logic               pick_ls;

    // State, latency counter, starvation counter and slot owner (1 = LS)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_cnt_q <= '0;
            starve_q  <= '0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            starve_q  <= starve_d;
            owner_q   <= owner_d;
        end
    end

    // Arbitration, next state, memory-side mux and response routing
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        starve_d  = starve_q;
        owner_d   = owner_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;

        resp = (state_q == S_WAIT)
            && (lat_cnt_q == LAT_W'(MEM_LAT));
        // Grants are suppressed while reset is held so nothing issues
        // against a memory whose response would be dropped.
        can_issue = !reset && ((state_q == S_IDLE) || resp);
        pick_if = if_req
            && (!ls_req || (starve_q == STV_W'(STARVE_MAX)));
        pick_ls = ls_req && !pick_if;

        if_gnt = can_issue && pick_if;
        ls_gnt = can_issue && pick_ls;
        busy   = (state_q == S_WAIT);

        if (state_q == S_WAIT) begin
            if (resp) begin
                state_d = S_IDLE;
            end else begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
        end

        if (resp) begin
            if (owner_q) begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_rdata;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
        end

        if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end

        if (if_gnt || ls_gnt) begin
            state_d   = S_WAIT;
            lat_cnt_d = LAT_W'(1);
            owner_d   = ls_gnt;
        end

        if (if_gnt) begin
            starve_d = '0;
        end else if (ls_gnt) begin
            if (!if_req) begin
                starve_d = '0;
            end else if (starve_q != STV_W'(STARVE_MAX)) begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model
// and per-requester response scoreboards.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] d;
        bit          care;
        int          c;
    } exp_t;

    exp_t ifq[$];
    exp_t lsq[$];
    exp_t me;

    logic [63:0] mem [logic [63:0]];
    logic [63:0] pipe [LAT];

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    // Memory: data appears on mem_rdata LAT cycles after the issue cycle
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 64'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic pif(input logic [63:0] d, input int c);
        exp_t e;
        e.d = d; e.care = 1'b1; e.c = c;
        ifq.push_back(e);
    endtask

    task automatic pls(input logic [63:0] d, input bit care, input int c);
        exp_t e;
        e.d = d; e.care = care; e.c = c;
        lsq.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && busy; i++) step();
        chk("drain_busy", 64'(busy), 64'h0);
        step();
    endtask

    // Response monitor: every rvalid must match the head of its queue
    always @(negedge clk) begin
        if (if_rvalid && ls_rvalid) chk("both_rvalid", 64'h1, 64'h0);
        if (ifq.size() > 0 && ifq[0].c < cyc) begin
            chk("if_rvalid_missed", 64'(cyc), 64'(ifq[0].c));
            void'(ifq.pop_front());
        end
        if (lsq.size() > 0 && lsq[0].c < cyc) begin
            chk("ls_rvalid_missed", 64'(cyc), 64'(lsq[0].c));
            void'(lsq.pop_front());
        end
        if (if_rvalid) begin
            if (ifq.size() == 0) begin
                chk("if_rvalid_unexp", 64'h1, 64'h0);
            end else begin
                me = ifq.pop_front();
                chk("if_rcyc", 64'(cyc), 64'(me.c));
                chk("if_rdata", if_rdata, me.d);
                chk("ls_rdata_idle", ls_rdata, 64'h0);
            end
        end
        if (ls_rvalid) begin
            if (lsq.size() == 0) begin
                chk("ls_rvalid_unexp", 64'h1, 64'h0);
            end else begin
                me = lsq.pop_front();
                chk("ls_rcyc", 64'(cyc), 64'(me.c));
                if (me.care) chk("ls_rdata", ls_rdata, me.d);
                chk("if_rdata_idle", if_rdata, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < LAT; i++) pipe[i] = 64'h0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        repeat (3) step();

        // Reset state, with a fetch request already pending
        if_req  = 1'b1;
        if_addr = 64'h10;
        neg();
        chk("rst_if_gnt", 64'(if_gnt), 64'h0);
        chk("rst_ls_gnt", 64'(ls_gnt), 64'h0);
        chk("rst_mem_en", 64'(mem_en), 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_if_rdata", if_rdata, 64'h0);
        chk("rst_ls_rdata", ls_rdata, 64'h0);

        // Single fetch
        step();
        reset = 1'b0;
        t = cyc;
        pif(pat(64'h10), t + 2);
        neg();
        chk("t1_if_gnt", 64'(if_gnt), 64'h1);
        chk("t1_ls_gnt", 64'(ls_gnt), 64'h0);
        chk("t1_mem_en", 64'(mem_en), 64'h1);
        chk("t1_mem_we", 64'(mem_we), 64'h0);
        chk("t1_mem_addr", mem_addr, 64'h10);
        chk("t1_mem_wdata", mem_wdata, 64'h0);
        step();
        if_req = 1'b0;
        neg();
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_mem_en_wait", 64'(mem_en), 64'h0);
        step();
        drain();

        // Simultaneous requests: LS first, then IF
        t = cyc;
        if_req  = 1'b1;
        if_addr = 64'h18;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 64'h40;
        pls(pat(64'h40), 1'b1, t + 2);
        pif(pat(64'h18), t + 4);
        neg();
        chk("t2_ls_gnt", 64'(ls_gnt), 64'h1);
        chk("t2_if_gnt", 64'(if_gnt), 64'h0);
        chk("t2_mem_addr", mem_addr, 64'h40);
        step();
        ls_req = 1'b0;
        neg();
        chk("t2_if_gnt_wait", 64'(if_gnt), 64'h0);
        step();
        neg();
        chk("t2_if_gnt_late", 64'(if_gnt), 64'h1);
        chk("t2_mem_addr_if", mem_addr, 64'h18);
        step();
        if_req = 1'b0;
        drain();

        // Starvation bound: four LS slots, then IF, then LS again
        t = cyc;
        if_req  = 1'b1;
        if_addr = 64'h20;
        ls_req  = 1'b1;
        ls_addr = 64'h48;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) pif(pat(64'h20), t + 2*k + 2);
            else pls(pat(64'h48), 1'b1, t + 2*k + 2);
        end
        for (int k = 0; k < 6; k++) begin
            neg();
            chk("t3_ls_gnt", 64'(ls_gnt), (k != 4) ? 64'h1 : 64'h0);
            chk("t3_if_gnt", 64'(if_gnt), (k == 4) ? 64'h1 : 64'h0);
            step();
            if (k == 4) if_req = 1'b0;
            if (k == 5) ls_req = 1'b0;
            if (k < 5) begin
                neg();
                chk("t3_gap", 64'(ls_gnt | if_gnt), 64'h0);
                step();
            end
        end
        drain();

        // Store, then read it back through the fetch port
        t = cyc;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 64'h80;
        ls_wdata = 64'hDEADBEEF;
        pls(64'h0, 1'b0, t + 2);
        neg();
        chk("t4_ls_gnt", 64'(ls_gnt), 64'h1);
        chk("t4_mem_we", 64'(mem_we), 64'h1);
        chk("t4_mem_addr", mem_addr, 64'h80);
        chk("t4_mem_wdata", mem_wdata, 64'hDEADBEEF);
        step();
        ls_req = 1'b0;
        ls_we  = 1'b0;
        drain();
        t = cyc;
        if_req  = 1'b1;
        if_addr = 64'h80;
        pif(64'hDEADBEEF, t + 2);
        neg();
        chk("t4_rb_gnt", 64'(if_gnt), 64'h1);
        step();
        if_req = 1'b0;
        drain();

        // Back-to-back fetches
        t = cyc;
        if_req  = 1'b1;
        if_addr = 64'h100;
        for (int k = 0; k < 3; k++) pif(pat(64'h100 + 64'(8*k)), t + 2*k + 2);
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("t6_if_gnt", 64'(if_gnt), 64'h1);
            if (k > 0) chk("t6_busy_resp", 64'(busy), 64'h1);
            step();
            if (k == 2) if_req = 1'b0;
            else if_addr = 64'h100 + 64'(8*(k+1));
            neg();
            chk("t6_busy", 64'(busy), 64'h1);
            chk("t6_gap", 64'(if_gnt), 64'h0);
            step();
        end
        neg();
        chk("t6_busy_last", 64'(busy), 64'h1);
        chk("t6_no_gnt", 64'(if_gnt), 64'h0);
        step();
        neg();
        chk("t6_idle", 64'(busy), 64'h0);
        step();

        // Reset during an outstanding load
        t = cyc;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 64'h58;
        neg();
        chk("t5_ls_gnt", 64'(ls_gnt), 64'h1);
        step();
        ls_req  = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h200;
        chk("t5_busy_pre", 64'(busy), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_busy_rst", 64'(busy), 64'h0);
        chk("t5_mem_en_rst", 64'(mem_en), 64'h0);
        chk("t5_if_gnt_rst", 64'(if_gnt), 64'h0);
        chk("t5_rvalid_rst", 64'(if_rvalid | ls_rvalid), 64'h0);
        step();
        neg();
        chk("t5_no_ls_rvalid", 64'(ls_rvalid), 64'h0);
        chk("t5_busy_held", 64'(busy), 64'h0);
        step();
        reset = 1'b0;
        t = cyc;
        pif(pat(64'h200), t + 2);
        neg();
        chk("t5_if_gnt_rel", 64'(if_gnt), 64'h1);
        chk("t5_mem_addr", mem_addr, 64'h200);
        step();
        if_req = 1'b0;
        drain();

        repeat (3) step();
        chk("ifq_empty", 64'(ifq.size()), 64'h0);
        chk("lsq_empty", 64'(lsq.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
